// File: rtl/sram_loader_pkg.sv
// Shared definitions for the SRAM loader: state encoding and its enum type.
package sram_loader_pkg;

    localparam logic [1:0] ST_IDLE_ENC   = 2'd0;
    localparam logic [1:0] ST_WRITE_ENC  = 2'd1;
    localparam logic [1:0] ST_VERIFY_ENC = 2'd2;
    localparam logic [1:0] ST_FINISH_ENC = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE_ENC,
        WRITE  = ST_WRITE_ENC,
        VERIFY = ST_VERIFY_ENC,
        FINISH = ST_FINISH_ENC
    } state_t;

endpackage

// File: rtl/sram_loader_if.sv
// Loader bundle: word stream handshake, SRAM port and status flags.
// master = the environment (producer + SRAM), slave = the loader.
interface sram_loader_if #(
    parameter int ADDR  = 4,
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             sram_cs;
    logic             sram_we;
    logic [ADDR-1:0]  sram_addr;
    logic [WIDTH-1:0] sram_wdata;
    logic [WIDTH-1:0] sram_rdata;
    logic             busy;
    logic             done;
    logic             error;

    modport master (
        output start, in_data, in_valid, sram_rdata,
        input  in_ready, sram_cs, sram_we, sram_addr, sram_wdata, busy, done, error
    );

    modport slave (
        input  start, in_data, in_valid, sram_rdata,
        output in_ready, sram_cs, sram_we, sram_addr, sram_wdata, busy, done, error
    );
endinterface

// File: rtl/sram_loader_csum.sv
// Clearable XOR accumulator used for the write and readback checksums.
module sram_loader_csum #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_csum
);
    logic [WIDTH-1:0] r_csum;

    // NOTE: non-blocking (<=) in clocked blocks so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      r_csum <= '0;
        else if (i_clr)  r_csum <= '0;
        else if (i_en)   r_csum <= r_csum ^ i_data;
    end

    assign o_csum = r_csum;
endmodule

// File: rtl/sram_loader.sv
// Streams LENGTH words into an SRAM; with LOADER_VERIFY_EN defined it reads
// them back and flags a checksum mismatch on error.
module sram_loader
    import sram_loader_pkg::*;
#(
    parameter int ADDR   = 4,
    parameter int WIDTH  = 8,
    parameter int LENGTH = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    sram_loader_if.slave bus
);
    localparam int               CNT_W     = ADDR + 1;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(LENGTH - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sram_cs;
    logic             r_sram_we;
    logic [ADDR-1:0]  r_sram_addr;
    logic [WIDTH-1:0] r_sram_wdata;
    logic             r_done;
    logic [WIDTH-1:0] w_wr_csum;
    logic             w_xfer;
    logic             w_clr;

    assign w_xfer = (r_state == WRITE) && bus.in_valid;
    assign w_clr  = (r_state == IDLE) && bus.start;

    sram_loader_csum #(.WIDTH(WIDTH)) u_wr_csum (
        .clk(clk), .rst_n(rst_n), .i_clr(w_clr), .i_en(w_xfer),
        .i_data(bus.in_data), .o_csum(w_wr_csum)
    );

`ifdef LOADER_VERIFY_EN
    localparam logic [CNT_W-1:0] LEN_CNT = CNT_W'(LENGTH);

    logic             r_rd_valid;
    logic             r_error;
    logic [WIDTH-1:0] w_rd_csum;

    // Read data is valid the cycle after a read sits on the bus.
    sram_loader_csum #(.WIDTH(WIDTH)) u_rd_csum (
        .clk(clk), .rst_n(rst_n), .i_clr(w_clr), .i_en(r_rd_valid),
        .i_data(bus.sram_rdata), .o_csum(w_rd_csum)
    );
`else
    logic w_unused;
    assign w_unused = ^{bus.sram_rdata, w_wr_csum};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_sram_cs    <= 1'b0;
            r_sram_we    <= 1'b0;
            r_sram_addr  <= '0;
            r_sram_wdata <= '0;
            r_done       <= 1'b0;
`ifdef LOADER_VERIFY_EN
            r_rd_valid   <= 1'b0;
            r_error      <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
`ifdef LOADER_VERIFY_EN
            r_rd_valid <= r_sram_cs && !r_sram_we;
`endif
            case (r_state)
                IDLE: begin
                    r_sram_cs <= 1'b0;
                    r_sram_we <= 1'b0;
                    if (bus.start) begin
                        r_state <= WRITE;
                        r_cnt   <= '0;
`ifdef LOADER_VERIFY_EN
                        r_error <= 1'b0;
`endif
                    end
                end
                WRITE: begin
                    r_sram_cs <= w_xfer;
                    r_sram_we <= w_xfer;
                    if (w_xfer) begin
                        r_sram_addr  <= r_cnt[ADDR-1:0];
                        r_sram_wdata <= bus.in_data;
                        if (r_cnt == LAST_WORD) begin
                            r_cnt <= '0;
`ifdef LOADER_VERIFY_EN
                            r_state <= VERIFY;
`else
                            r_state <= FINISH;
                            r_done  <= 1'b1;
`endif
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
`ifdef LOADER_VERIFY_EN
                // The last read's data lands during FINISH and is folded in there.
                VERIFY: begin
                    r_sram_we <= 1'b0;
                    if (r_cnt == LEN_CNT) begin
                        r_sram_cs <= 1'b0;
                        r_state   <= FINISH;
                        r_done    <= 1'b1;
                    end else begin
                        r_sram_cs   <= 1'b1;
                        r_sram_addr <= r_cnt[ADDR-1:0];
                        r_cnt       <= r_cnt + 1'b1;
                    end
                end
`endif
                FINISH: begin
                    r_sram_cs <= 1'b0;
                    r_sram_we <= 1'b0;
                    r_state   <= IDLE;
`ifdef LOADER_VERIFY_EN
                    if (w_wr_csum != (w_rd_csum ^ bus.sram_rdata)) r_error <= 1'b1;
`endif
                end
                // NOTE: a default arm keeps every path assigned, so no latch or stuck state.
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready   = (r_state == WRITE);
    assign bus.busy       = (r_state != IDLE);
    assign bus.sram_cs    = r_sram_cs;
    assign bus.sram_we    = r_sram_we;
    assign bus.sram_addr  = r_sram_addr;
    assign bus.sram_wdata = r_sram_wdata;
    assign bus.done       = r_done;
`ifdef LOADER_VERIFY_EN
    assign bus.error      = r_error;
`else
    assign bus.error      = 1'b0;
`endif
endmodule

// File: tb/tb_sram_loader.sv
// Directed bench for sram_loader with an SRAM model and a write scoreboard;
// expectations adapt to LOADER_VERIFY_EN.
module tb_sram_loader;
    localparam int ADDR   = 4;
    localparam int WIDTH  = 8;
    localparam int LENGTH = 16;
`ifdef LOADER_VERIFY_EN
    localparam bit VER = 1'b1;
`else
    localparam bit VER = 1'b0;
`endif
    localparam int BUSY_FULL = VER ? (2 * LENGTH + 2) : (LENGTH + 1);

    typedef struct {
        logic [ADDR-1:0]  addr;
        logic [WIDTH-1:0] data;
    } wr_t;

    logic clk;
    logic rst_n;
    sram_loader_if #(.ADDR(ADDR), .WIDTH(WIDTH)) bus ();

    sram_loader #(.ADDR(ADDR), .WIDTH(WIDTH), .LENGTH(LENGTH)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [WIDTH-1:0] mem [0:LENGTH-1];
    bit corrupt;
    wr_t sb [$];
    wr_t mon_e;
    int n_tests, n_fail;
    int n_busy, n_done, n_wr_load, n_wr_total, n_rd, rd_exp;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // SRAM model: synchronous write, registered read, optional corruption at address 5
    always @(posedge clk) begin
        if (bus.sram_cs) begin
            if (bus.sram_we) mem[bus.sram_addr] <= bus.sram_wdata;
            else bus.sram_rdata <= mem[bus.sram_addr] ^
                ((corrupt && bus.sram_addr == 4'd5) ? 8'h01 : 8'h00);
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.busy) n_busy++;
            if (bus.done) n_done++;
            if (bus.sram_cs && bus.sram_we) begin
                n_wr_load++;
                n_wr_total++;
                if (sb.size() == 0) begin
                    check("unexpected_write", 32'(sb.size()), 32'd1);
                end else begin
                    mon_e = sb.pop_front();
                    check("write_addr", 32'(bus.sram_addr), 32'(mon_e.addr));
                    check("write_data", 32'(bus.sram_wdata), 32'(mon_e.data));
                end
            end
            if (bus.sram_cs && !bus.sram_we) begin
                n_rd++;
                check("read_addr", 32'(bus.sram_addr), 32'(rd_exp));
                rd_exp++;
            end
        end
    end

    task automatic run_load(input int nwords, input bit gap, input bit poke, input logic [7:0] base);
        int k;
        int guard;
        wr_t e;
        k = 0;
        guard = 0;
        n_busy = 0; n_done = 0; n_wr_load = 0; n_rd = 0; rd_exp = 0;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("busy_after_start", 32'(bus.busy), 32'd1);
        check("error_clr_on_start", 32'(bus.error), 32'd0);
        while (k < nwords && guard < 4 * LENGTH) begin
            bus.in_valid = gap ? (guard % 2 == 0) : 1'b1;
            bus.in_data  = base + 8'(k);
            bus.start    = poke && (guard == 3);
            @(negedge clk);
            check("in_ready_write", 32'(bus.in_ready), 32'd1);
            if (bus.in_valid) begin
                e.addr = 4'(k);
                e.data = bus.in_data;
                sb.push_back(e);
                k++;
            end
            @(posedge clk); #1;
            guard++;
        end
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;
        if (k < nwords) check("xfer_timeout", 32'(k), 32'(nwords));
        if (poke && nwords == LENGTH) begin
            bus.start = 1'b1;
            @(posedge clk); #1;
            bus.start = 1'b0;
        end
    endtask

    task automatic finish_load(input int exp_busy, input bit exp_err);
        int i;
        @(negedge clk);
        check("in_ready_after_last", 32'(bus.in_ready), 32'd0);
        for (i = 0; i < 200 && n_done == 0; i++) @(posedge clk);
        if (n_done == 0) check("done_timeout", 32'(n_done), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("done_once", 32'(n_done), 32'd1);
        check("busy_idle", 32'(bus.busy), 32'd0);
        check("sb_empty", 32'(sb.size()), 32'd0);
        check("writes_per_load", 32'(n_wr_load), 32'(LENGTH));
        check("reads_per_load", 32'(n_rd), VER ? 32'(LENGTH) : 32'd0);
        check("error_flag", 32'(bus.error), 32'(exp_err));
        if (exp_busy > 0) check("busy_cycles", 32'(n_busy), 32'(exp_busy));
    endtask

    task automatic check_mem(input logic [7:0] base);
        for (int i = 0; i < LENGTH; i++)
            check($sformatf("mem[%0d]", i), 32'(mem[i]), 32'(base + 8'(i)));
    endtask

    initial begin
        int wr_before;
        n_tests = 0; n_fail = 0; corrupt = 1'b0;
        bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_cs", 32'(bus.sram_cs), 32'd0);
        check("rst_we", 32'(bus.sram_we), 32'd0);
        check("rst_addr", 32'(bus.sram_addr), 32'd0);
        check("rst_wdata", 32'(bus.sram_wdata), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_error", 32'(bus.error), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // back-to-back words 0x00..0x0F
        run_load(LENGTH, 1'b0, 1'b0, 8'h00);
        finish_load(BUSY_FULL, 1'b0);
        check_mem(8'h00);

        // corrupted readback at address 5 (flags error only with verify)
        corrupt = 1'b1;
        run_load(LENGTH, 1'b0, 1'b0, 8'h80);
        finish_load(BUSY_FULL, VER);
        corrupt = 1'b0;

        // gapped in_valid plus start pokes during WRITE and after the last word
        run_load(LENGTH, 1'b1, 1'b1, 8'h40);
        finish_load(-1, 1'b0);
        check_mem(8'h40);

        // reset after the 7th transfer abandons the load
        run_load(7, 1'b0, 1'b0, 8'hC0);
        rst_n = 1'b0;
        #1;
        check("abort_cs", 32'(bus.sram_cs), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_in_ready", 32'(bus.in_ready), 32'd0);
        check("abort_pending", 32'(sb.size()), 32'd1);
        sb.delete();
        wr_before = n_wr_total;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("no_writes_after_abort", 32'(n_wr_total), 32'(wr_before));
        check("idle_after_abort", 32'(bus.busy), 32'd0);

        run_load(LENGTH, 1'b0, 1'b0, 8'h20);
        finish_load(BUSY_FULL, 1'b0);
        check_mem(8'h20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
